md_issue: RTL and testbench

MD_ISSUE -- requirements
Module: md_issue

---
 rtl/md_issue.sv | 238 +++++++++++++++++++++++
 tb/tb_md_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue.sv
// md_issue: issue stage between the E pipeline stage and the multiply/divide
// unit. Holds a one-cycle issue register plus a single-entry buffer so a new
// START/MT op can be accepted while the unit (or a just-issued op) is busy.
// MF reads bypass the issue register combinationally when not stalled.
// Optional feature: define MD_DIV0_SKIP_EN to drop div/divu with B == 0 at
// issue and report it on div0 instead.

`ifndef MD_NONE
`define MD_NONE  4'd0
`define MD_mult  4'd1
`define MD_multu 4'd2
`define MD_div   4'd3
`define MD_divu  4'd4
`define MD_mthi  4'd5
`define MD_mtlo  4'd6
`define MD_mfhi  4'd7
`define MD_mflo  4'd8
`endif

module md_issue #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Req,
    input  logic                   in_valid,
    input  logic [3:0]             in_op,
    input  logic [31:0]            in_A,
    input  logic [31:0]            in_B,
    input  logic                   md_busy,
    output logic                   in_stall,
    output logic                   md_start,
    output logic [3:0]             md_op,
    output logic [31:0]            md_A,
    output logic [31:0]            md_B,
    output logic                   div0,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Op codes that kick off a multiply/divide operation.
    function automatic logic op_is_start(input logic [3:0] op);
        logic r;
        case (op)
            `MD_mult, `MD_multu, `MD_div, `MD_divu: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // Op codes that write HI/LO.
    function automatic logic op_is_mt(input logic [3:0] op);
        logic r;
        case (op)
            `MD_mthi, `MD_mtlo: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    // Op codes that read HI/LO.
    function automatic logic op_is_mf(input logic [3:0] op);
        logic r;
        case (op)
            `MD_mfhi, `MD_mflo: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

    // Divide op codes (subject to the divide-by-zero drop).
    function automatic logic op_is_div(input logic [3:0] op);
        logic r;
        case (op)
            `MD_div, `MD_divu: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    logic                   md_start_r;
    logic [3:0]             md_op_r;
    logic [31:0]            md_a_r;
    logic [31:0]            md_b_r;
    logic                   buf_valid_r;
    logic [3:0]             buf_op_r;
    logic [31:0]            buf_a_r;
    logic [31:0]            buf_b_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic                   issue_class_s;
    logic                   read_class_s;
    logic                   pend_s;
    logic                   busy_eff_s;
    logic                   in_stall_s;
    logic                   accept_s;
    logic                   read_s;
    logic                   iss_valid_s;
    logic [3:0]             iss_op_s;
    logic [31:0]            iss_a_s;
    logic [31:0]            iss_b_s;
    logic                   buf_load_s;
    logic                   skip_s;

    assign issue_class_s = op_is_start(in_op) | op_is_mt(in_op);
    assign read_class_s  = op_is_mf(in_op);

    // An op sitting in the issue register still counts as busy for one cycle.
    assign pend_s     = (md_op_r != `MD_NONE);
    assign busy_eff_s = md_busy | pend_s;

    // Stall decision: START/MT only wait when the buffer is already full,
    // MF must wait for all outstanding work to drain.
    always_comb begin
        in_stall_s = 1'b0;
        if (!reset || Req) begin
            in_stall_s = 1'b0;
        end else if (!in_valid) begin
            in_stall_s = 1'b0;
        end else if (issue_class_s) begin
            in_stall_s = buf_valid_r & busy_eff_s;
        end else if (read_class_s) begin
            in_stall_s = busy_eff_s | buf_valid_r;
        end else begin
            in_stall_s = 1'b0;
        end
    end

    assign accept_s = reset & ~Req & in_valid & issue_class_s & ~in_stall_s;
    assign read_s   = reset & ~Req & in_valid & read_class_s  & ~in_stall_s;

    // Issue selection: the buffer always goes first; a new op that cannot
    // issue this edge (busy, or behind the buffer) is captured in the buffer.
    always_comb begin
        iss_valid_s = 1'b0;
        iss_op_s    = in_op;
        iss_a_s     = in_A;
        iss_b_s     = in_B;
        buf_load_s  = 1'b0;
        if (busy_eff_s) begin
            iss_valid_s = 1'b0;
            buf_load_s  = accept_s;
        end else if (buf_valid_r) begin
            iss_valid_s = 1'b1;
            iss_op_s    = buf_op_r;
            iss_a_s     = buf_a_r;
            iss_b_s     = buf_b_r;
            buf_load_s  = accept_s;
        end else begin
            iss_valid_s = accept_s;
            buf_load_s  = 1'b0;
        end
    end

`ifdef MD_DIV0_SKIP_EN
    assign skip_s = iss_valid_s & op_is_div(iss_op_s) & (iss_b_s == 32'd0);
`else
    assign skip_s = 1'b0;
`endif

    // Issue register and one-entry buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_start_r  <= 1'b0;
            md_op_r     <= `MD_NONE;
            md_a_r      <= 32'd0;
            md_b_r      <= 32'd0;
            buf_valid_r <= 1'b0;
            buf_op_r    <= `MD_NONE;
            buf_a_r     <= 32'd0;
            buf_b_r     <= 32'd0;
        end else if (Req) begin
            md_start_r  <= 1'b0;
            md_op_r     <= `MD_NONE;
            buf_valid_r <= 1'b0;
            buf_op_r    <= `MD_NONE;
            buf_a_r     <= 32'd0;
            buf_b_r     <= 32'd0;
        end else begin
            if (iss_valid_s && !skip_s) begin
                md_start_r <= op_is_start(iss_op_s);
                md_op_r    <= iss_op_s;
                md_a_r     <= iss_a_s;
                md_b_r     <= iss_b_s;
            end else begin
                md_start_r <= 1'b0;
                md_op_r    <= `MD_NONE;
            end
            if (buf_load_s) begin
                buf_valid_r <= 1'b1;
                buf_op_r    <= in_op;
                buf_a_r     <= in_A;
                buf_b_r     <= in_B;
            end else if (iss_valid_s && buf_valid_r) begin
                buf_valid_r <= 1'b0;
            end else begin
                buf_valid_r <= buf_valid_r;
            end
        end
    end

`ifdef MD_DIV0_SKIP_EN
    logic div0_r;

    // One-cycle pulse for a divide dropped because its divisor was zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div0_r <= 1'b0;
        end else if (Req) begin
            div0_r <= 1'b0;
        end else begin
            div0_r <= skip_s;
        end
    end

    assign div0 = div0_r;
`else
    assign div0 = 1'b0;
`endif

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (in_stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_stall     = in_stall_s;
    assign md_start     = md_start_r;
    assign md_op        = read_s ? in_op : md_op_r;
    assign md_A         = md_a_r;
    assign md_B         = md_b_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_md_issue.sv
// Directed table-driven bench for md_issue, plus hand sequences for reset,
// flush-with-reset priority, MF stall counting and counter saturation.
module tb_md_issue;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;

`ifdef MD_DIV0_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic        md_busy;

    logic        in_stall,  in_stall2;
    logic        md_start,  md_start2;
    logic [3:0]  md_op,     md_op2;
    logic [31:0] md_A,      md_A2;
    logic [31:0] md_B,      md_B2;
    logic        div0,      div0_2;
    logic [31:0] stall_cycles;
    logic [1:0]  stall_cycles2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_issue #(.STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Req(Req), .in_valid(in_valid), .in_op(in_op),
        .in_A(in_A), .in_B(in_B), .md_busy(md_busy), .in_stall(in_stall),
        .md_start(md_start), .md_op(md_op), .md_A(md_A), .md_B(md_B),
        .div0(div0), .stall_cycles(stall_cycles)
    );

    md_issue #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .Req(Req), .in_valid(in_valid), .in_op(in_op),
        .in_A(in_A), .in_B(in_B), .md_busy(md_busy), .in_stall(in_stall2),
        .md_start(md_start2), .md_op(md_op2), .md_A(md_A2), .md_B(md_B2),
        .div0(div0_2), .stall_cycles(stall_cycles2)
    );

    typedef struct {
        logic        req;
        logic        vld;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        e_stall;
        logic        e_start;
        logic [3:0]  e_op;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_div0;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic req, input logic vld, input logic [3:0] op,
                                input logic [31:0] a, input logic [31:0] b, input logic busy,
                                input logic e_stall, input logic e_start, input logic [3:0] e_op,
                                input logic [31:0] e_a, input logic [31:0] e_b, input logic e_div0);
        vec_t v;
        v.req = req; v.vld = vld; v.op = op; v.a = a; v.b = b; v.busy = busy;
        v.e_stall = e_stall; v.e_start = e_start; v.e_op = e_op;
        v.e_a = e_a; v.e_b = e_b; v.e_div0 = e_div0;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic vld, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic busy);
        Req = req; in_valid = vld; in_op = op; in_A = a; in_B = b; md_busy = busy;
    endtask

    task automatic drive_rand();
        Req = 1'($urandom); in_valid = 1'($urandom); in_op = 4'($urandom_range(0, 9));
        in_A = $urandom; in_B = $urandom; md_busy = 1'($urandom);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_stall", idx, {31'd0, in_stall}, 32'd0);
        chk("rst_start", idx, {31'd0, md_start}, 32'd0);
        chk("rst_op", idx, {28'd0, md_op}, 32'd0);
        chk("rst_A", idx, md_A, 32'd0);
        chk("rst_B", idx, md_B, 32'd0);
        chk("rst_div0", idx, {31'd0, div0}, 32'd0);
        chk("rst_cnt", idx, stall_cycles, 32'd0);
        chk("rst_cnt2", idx, {30'd0, stall_cycles2}, 32'd0);
    endtask

    initial begin
        // idle / back-to-back issue
        vecs[0]  = mk(0,1,MULT ,3  ,5,0, 0,0,NONE ,0  ,0 ,0);
        vecs[1]  = mk(0,0,NONE ,0  ,0,0, 0,1,MULT ,3  ,5 ,0);
        vecs[2]  = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,3  ,5 ,0);
        // mult then divu buffered behind a busy unit
        vecs[3]  = mk(0,1,MULT ,10 ,20,0, 0,0,NONE ,3  ,5 ,0);
        vecs[4]  = mk(0,1,DIVU ,100,7,1, 0,1,MULT ,10 ,20,0);
        vecs[5]  = mk(0,0,NONE ,0  ,0,1, 0,0,NONE ,10 ,20,0);
        vecs[6]  = mk(0,1,MTHI ,1  ,2,1, 1,0,NONE ,10 ,20,0);
        vecs[7]  = mk(0,1,MFLO ,0  ,0,1, 1,0,NONE ,10 ,20,0);
        vecs[8]  = mk(0,0,NONE ,0  ,0,1, 0,0,NONE ,10 ,20,0);
        vecs[9]  = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,10 ,20,0);
        vecs[10] = mk(0,0,NONE ,0  ,0,1, 0,1,DIVU ,100,7 ,0);
        vecs[11] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        // flush of a buffered div
        vecs[12] = mk(0,1,DIV  ,50 ,5,1, 0,0,NONE ,100,7 ,0);
        vecs[13] = mk(1,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        vecs[14] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        vecs[15] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        // flush blocks acceptance
        vecs[16] = mk(1,1,MULT ,9  ,9,0, 0,0,NONE ,100,7 ,0);
        vecs[17] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        // MF read path, non-MD op ignored
        vecs[18] = mk(0,1,MFHI ,0  ,0,0, 0,0,MFHI ,100,7 ,0);
        vecs[19] = mk(0,1,4'd9 ,1  ,1,1, 0,0,NONE ,100,7 ,0);
        vecs[20] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,100,7 ,0);
        // MT issue: md_op shows it, no start
        vecs[21] = mk(0,1,MTLO ,11 ,12,0, 0,0,NONE ,100,7 ,0);
        vecs[22] = mk(0,0,NONE ,0  ,0,0, 0,0,MTLO ,11 ,12,0);
        vecs[23] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,11 ,12,0);
        // buffer issues while a new op enters the buffer at the same edge
        vecs[24] = mk(0,1,MULT ,1  ,2,0, 0,0,NONE ,11 ,12,0);
        vecs[25] = mk(0,1,MULTU,3  ,4,1, 0,1,MULT ,1  ,2 ,0);
        vecs[26] = mk(0,1,DIV  ,5  ,6,0, 0,0,NONE ,1  ,2 ,0);
        vecs[27] = mk(0,0,NONE ,0  ,0,0, 0,1,MULTU,3  ,4 ,0);
        vecs[28] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,3  ,4 ,0);
        vecs[29] = mk(0,0,NONE ,0  ,0,0, 0,1,DIV  ,5  ,6 ,0);
        vecs[30] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE ,5  ,6 ,0);
        // divide by zero
        vecs[31] = mk(0,1,DIV  ,8  ,0,0, 0,0,NONE ,5  ,6 ,0);
        vecs[32] = mk(0,0,NONE ,0  ,0,0, 0, SKIP ? 1'b0 : 1'b1, SKIP ? NONE : DIV,
                      SKIP ? 32'd5 : 32'd8, SKIP ? 32'd6 : 32'd0, SKIP);
        vecs[33] = mk(0,0,NONE ,0  ,0,0, 0,0,NONE , SKIP ? 32'd5 : 32'd8,
                      SKIP ? 32'd6 : 32'd0, 0);

        // reset with random inputs
        reset = 1'b0;
        drive_rand();
        next_edge();
        for (int i = 0; i < 2; i++) begin
            drive_rand();
            @(negedge clk);
            chk_all_zero(i);
            next_edge();
        end
        reset = 1'b1;

        // table
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].req, vecs[i].vld, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].busy);
            @(negedge clk);
            chk("stall", i, {31'd0, in_stall}, {31'd0, vecs[i].e_stall});
            chk("start", i, {31'd0, md_start}, {31'd0, vecs[i].e_start});
            chk("op", i, {28'd0, md_op}, {28'd0, vecs[i].e_op});
            chk("A", i, md_A, vecs[i].e_a);
            chk("B", i, md_B, vecs[i].e_b);
            chk("div0", i, {31'd0, div0}, {31'd0, vecs[i].e_div0});
            next_edge();
        end

        // reset beats flush and discards a buffered op
        drive(0, 1, MULT, 21, 22, 0);
        next_edge();
        drive(0, 1, MULT, 23, 24, 1);
        next_edge();
        reset = 1'b0;
        drive(1, 0, NONE, 0, 0, 0);
        next_edge();
        reset = 1'b1;
        drive(0, 0, NONE, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rp_start", i, {31'd0, md_start}, 32'd0);
            chk("rp_op", i, {28'd0, md_op}, 32'd0);
            chk("rp_A", i, md_A, 32'd0);
            next_edge();
        end

        // MF stalls for exactly the busy window
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, MFHI, 0, 0, 1);
            @(negedge clk);
            chk("mf_stall", i, {31'd0, in_stall}, 32'd1);
            chk("mf_op", i, {28'd0, md_op}, 32'd0);
            next_edge();
        end
        drive(0, 1, MFHI, 0, 0, 0);
        @(negedge clk);
        chk("mf_stall", 4, {31'd0, in_stall}, 32'd0);
        chk("mf_op", 4, {28'd0, md_op}, {28'd0, MFHI});
        chk("mf_start", 4, {31'd0, md_start}, 32'd0);
        chk("mf_cnt", 4, stall_cycles, 32'd4);
        chk("mf_cnt_sat", 4, {30'd0, stall_cycles2}, 32'd3);
        next_edge();
        drive(0, 0, NONE, 0, 0, 0);
        @(negedge clk);
        chk("mf_cnt", 5, stall_cycles, 32'd4);
        chk("mf_cnt_sat", 5, {30'd0, stall_cycles2}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
